// File: rtl/irq_pkg.sv
// Shared types and limits for the interrupt controller.
//   irq_state_t : controller FSM state encoding
//   IRQ_MAX_SRC : largest supported number of interrupt sources
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERVICE
  } irq_state_t;

  localparam int IRQ_MAX_SRC = 16;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index of req wins.
// Ports:
//   req   in  NUM_SRC  request vector
//   valid out 1        any request set
//   idx   out ID_W     index of the lowest set request (0 when none)
module irq_prio_enc #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller between external event sources and fetch.
// Rising edges on irq_src set pending bits; unmasked pending sources are
// arbitrated lowest-index-first. One request is serviced at a time: the
// winner's id and payload are captured at grant, interrupt is raised for
// exactly one non-stalled cycle, and the lock is held until rti or rsi.
//
// Configuration macro: IRQ_SYNC_EN -- when defined, irq_src passes through a
// 2-flop synchronizer per bit (two extra cycles edge->pending).
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   irq_src       level inputs, rising edge requests
//   src_data      per-source payload, source i at [i*DATA_W +: DATA_W]
//   mask_wr_en    load mask_wr_data into the mask register (1 = blocked)
//   rti, rsi      release the in-service lock (ignored outside SERVICE)
//   stall         holds the redirect request while high
//   interrupt     redirect/flush request to fetch
//   irq_id        index of the serviced source
//   irq_data      payload captured at grant
//   in_service    high from grant until release
//   pending       current pending bits
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        irq_src,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      mask_wr_en,
  input  logic [NUM_SRC-1:0]        mask_wr_data,
  input  logic                      rti,
  input  logic                      rsi,
  input  logic                      stall,
  output logic                      interrupt,
  output logic [ID_W-1:0]           irq_id,
  output logic [DATA_W-1:0]         irq_data,
  output logic                      in_service,
  output logic [NUM_SRC-1:0]        pending
);

  if (NUM_SRC < 1 || NUM_SRC > IRQ_MAX_SRC) begin : g_bad_num_src
    $error("irq_ctrl: NUM_SRC out of range");
  end

  irq_state_t          state, state_nxt;
  logic [NUM_SRC-1:0]  irq_src_q;
  logic [NUM_SRC-1:0]  irq_src_prev;
  logic [NUM_SRC-1:0]  pend_q;
  logic [NUM_SRC-1:0]  mask_q;
  logic [NUM_SRC-1:0]  pend_set;
  logic [NUM_SRC-1:0]  pend_clr;
  logic [NUM_SRC-1:0]  pend_nxt;
  logic [NUM_SRC-1:0]  req;
  logic                win_valid;
  logic [ID_W-1:0]     win_idx;
  logic [DATA_W-1:0]   win_data;
  logic                grant;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_s1;
  logic [NUM_SRC-1:0] sync_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= irq_src;
      sync_s2 <= sync_s1;
    end
  end

  assign irq_src_q = sync_s2;
`else
  assign irq_src_q = irq_src;
`endif

  assign pend_set = irq_src_q & ~irq_src_prev;
  assign req      = pend_q & ~mask_q;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio (
    .req   (req),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    case (state)
      IRQ_IDLE: begin
        if (win_valid) begin
          grant     = 1'b1;
          state_nxt = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        if (!stall) state_nxt = IRQ_SERVICE;
      end
      IRQ_SERVICE: begin
        if (rti || rsi) state_nxt = IRQ_IDLE;
      end
      default: state_nxt = IRQ_IDLE;
    endcase
  end

  // Clear mask and payload mux are decoded by comparison so non-power-of-two
  // NUM_SRC never indexes past the vector.
  always_comb begin
    pend_clr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (win_idx == ID_W'(i)) begin
        pend_clr[i] = grant;
        win_data    = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Set is OR-ed after the clear so a fresh edge is never lost.
  assign pend_nxt = (pend_q & ~pend_clr) | pend_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IRQ_IDLE;
      irq_src_prev <= '0;
      pend_q       <= '0;
      mask_q       <= '0;
      irq_id       <= '0;
      irq_data     <= '0;
    end else begin
      state        <= state_nxt;
      irq_src_prev <= irq_src_q;
      pend_q       <= pend_nxt;
      if (mask_wr_en) mask_q <= mask_wr_data;
      if (grant) begin
        irq_id   <= win_idx;
        irq_data <= win_data;
      end
    end
  end

  assign interrupt  = (state == IRQ_REQ);
  assign in_service = (state != IRQ_IDLE);
  assign pending    = pend_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   irq_src;
  logic [127:0] src_data;
  logic         mask_wr_en;
  logic [3:0]   mask_wr_data;
  logic         rti;
  logic         rsi;
  logic         stall;
  logic         interrupt;
  logic [1:0]   irq_id;
  logic [31:0]  irq_data;
  logic         in_service;
  logic [3:0]   pending;

  int tests = 0;
  int fails = 0;

  irq_ctrl #(.NUM_SRC(4), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_src      (irq_src),
    .src_data     (src_data),
    .mask_wr_en   (mask_wr_en),
    .mask_wr_data (mask_wr_data),
    .rti          (rti),
    .rsi          (rsi),
    .stall        (stall),
    .interrupt    (interrupt),
    .irq_id       (irq_id),
    .irq_data     (irq_data),
    .in_service   (in_service),
    .pending      (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; irq_src = '0; mask_wr_en = 1'b0; mask_wr_data = '0;
    rti = 1'b0; rsi = 1'b0; stall = 1'b0;
    src_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hDEAD_0000};
    tick(3);
    rst = 1'b0;
    tick(1);
    tests++;
    if ({interrupt, in_service} !== 2'b00) begin
      fails++; $display("FAIL reset_ctl: got int=%b svc=%b want 0 0", interrupt, in_service);
    end
    tests++;
    if ({pending, irq_id, irq_data} !== 38'd0) begin
      fails++; $display("FAIL reset_regs: got pend=%b id=%0d data=%h want 0", pending, irq_id, irq_data);
    end
  endtask

  task automatic test_single;
    irq_src = '0; tick(4);
    irq_src[0] = 1'b1;
    tick(1 + SL);
    tests++;
    if (pending !== 4'b0001 || interrupt !== 1'b0) begin
      fails++; $display("FAIL single_pend: got pend=%b int=%b want 0001 0", pending, interrupt);
    end
    tick(1);
    tests++;
    if (interrupt !== 1'b1 || irq_id !== 2'd0 || irq_data !== 32'hDEAD_0000) begin
      fails++; $display("FAIL single_grant: got int=%b id=%0d data=%h want 1 0 dead0000", interrupt, irq_id, irq_data);
    end
    tests++;
    if (pending !== 4'b0000 || in_service !== 1'b1) begin
      fails++; $display("FAIL single_clr: got pend=%b svc=%b want 0000 1", pending, in_service);
    end
    tick(1);
    tests++;
    if (interrupt !== 1'b0 || in_service !== 1'b1) begin
      fails++; $display("FAIL single_svc: got int=%b svc=%b want 0 1", interrupt, in_service);
    end
    rti = 1'b1; tick(1); rti = 1'b0;
    tests++;
    if (in_service !== 1'b0) begin
      fails++; $display("FAIL single_rel: got svc=%b want 0", in_service);
    end
  endtask

  task automatic test_back_to_back;
    irq_src = '0; tick(4);
    irq_src = 4'b1010;
    tick(1 + SL);
    tests++;
    if (pending !== 4'b1010) begin
      fails++; $display("FAIL b2b_pend: got %b want 1010", pending);
    end
    tick(1);
    tests++;
    if (interrupt !== 1'b1 || irq_id !== 2'd1 || irq_data !== 32'h1111_0001 || pending !== 4'b1000) begin
      fails++; $display("FAIL b2b_first: got int=%b id=%0d data=%h pend=%b want 1 1 11110001 1000",
                        interrupt, irq_id, irq_data, pending);
    end
    tick(3);
    tests++;
    if (interrupt !== 1'b0 || in_service !== 1'b1 || irq_id !== 2'd1) begin
      fails++; $display("FAIL b2b_hold: got int=%b svc=%b id=%0d want 0 1 1", interrupt, in_service, irq_id);
    end
    rti = 1'b1; tick(1); rti = 1'b0;
    tests++;
    if (interrupt !== 1'b0 || in_service !== 1'b0) begin
      fails++; $display("FAIL b2b_idle: got int=%b svc=%b want 0 0", interrupt, in_service);
    end
    tick(1);
    tests++;
    if (interrupt !== 1'b1 || irq_id !== 2'd3 || irq_data !== 32'h3333_0003) begin
      fails++; $display("FAIL b2b_second: got int=%b id=%0d data=%h want 1 3 33330003", interrupt, irq_id, irq_data);
    end
    tick(1);
    rti = 1'b1; tick(1); rti = 1'b0;
  endtask

  task automatic test_mask;
    irq_src = '0; tick(4);
    mask_wr_en = 1'b1; mask_wr_data = 4'b0100; tick(1); mask_wr_en = 1'b0;
    irq_src[2] = 1'b1;
    tick(1 + SL + 3);
    tests++;
    if (pending !== 4'b0100 || interrupt !== 1'b0 || in_service !== 1'b0) begin
      fails++; $display("FAIL mask_block: got pend=%b int=%b svc=%b want 0100 0 0", pending, interrupt, in_service);
    end
    mask_wr_en = 1'b1; mask_wr_data = 4'b0000; tick(1); mask_wr_en = 1'b0;
    tests++;
    if (interrupt !== 1'b0) begin
      fails++; $display("FAIL mask_early: got int=%b want 0", interrupt);
    end
    tick(1);
    tests++;
    if (interrupt !== 1'b1 || irq_id !== 2'd2 || irq_data !== 32'h2222_0002) begin
      fails++; $display("FAIL mask_grant: got int=%b id=%0d data=%h want 1 2 22220002", interrupt, irq_id, irq_data);
    end
    tick(1);
    rsi = 1'b1; tick(1); rsi = 1'b0;
    tests++;
    if (in_service !== 1'b0) begin
      fails++; $display("FAIL mask_rsi: got svc=%b want 0", in_service);
    end
  endtask

  task automatic test_stall;
    int hi;
    irq_src = '0; tick(4);
    irq_src[0] = 1'b1;
    tick(1 + SL + 1);
    stall = 1'b1;
    hi = 0;
    for (int k = 0; k < 5; k++) begin
      if (interrupt === 1'b1) hi++;
      tick(1);
    end
    stall = 1'b0;
    tests++;
    if (hi !== 5) begin
      fails++; $display("FAIL stall_hold: got %0d high cycles want 5", hi);
    end
    rti = 1'b1;
    tests++;
    if (interrupt !== 1'b1) begin
      fails++; $display("FAIL stall_last: got int=%b want 1", interrupt);
    end
    tick(1);
    rti = 1'b0;
    tests++;
    if (interrupt !== 1'b0 || in_service !== 1'b1) begin
      fails++; $display("FAIL stall_svc: got int=%b svc=%b want 0 1", interrupt, in_service);
    end
    rti = 1'b1; tick(1); rti = 1'b0;
  endtask

  task automatic test_reset_mid;
    irq_src = '0; tick(4);
    mask_wr_en = 1'b1; mask_wr_data = 4'b1000; tick(1); mask_wr_en = 1'b0;
    irq_src = 4'b1100;
    tick(1 + SL + 2);
    tests++;
    if (in_service !== 1'b1 || irq_id !== 2'd2 || pending !== 4'b1000) begin
      fails++; $display("FAIL rstmid_pre: got svc=%b id=%0d pend=%b want 1 2 1000", in_service, irq_id, pending);
    end
    #2 rst = 1'b1;
    irq_src = '0;
    #1;
    tests++;
    if ({interrupt, in_service, pending, irq_id} !== 8'd0 || irq_data !== 32'd0) begin
      fails++; $display("FAIL rstmid_async: got int=%b svc=%b pend=%b id=%0d data=%h want all 0",
                        interrupt, in_service, pending, irq_id, irq_data);
    end
    #1 rst = 1'b0;
    tick(4);
    irq_src[3] = 1'b1;
    tick(1 + SL + 1);
    tests++;
    if (interrupt !== 1'b1 || irq_id !== 2'd3) begin
      fails++; $display("FAIL rstmid_mask: got int=%b id=%0d want 1 3", interrupt, irq_id);
    end
    tick(1);
    rti = 1'b1; tick(1); rti = 1'b0;
  endtask

  task automatic test_level;
    int grants;
    irq_src = '0; tick(4);
    irq_src[0] = 1'b1;
    grants = 0;
    for (int k = 0; k < 24; k++) begin
      tick(1);
      if (interrupt === 1'b1) grants++;
      rti = in_service & ~interrupt;
    end
    rti = 1'b0;
    tick(1);
    tests++;
    if (grants !== 1 || in_service !== 1'b0 || pending !== 4'b0000) begin
      fails++; $display("FAIL level_once: got grants=%0d svc=%b pend=%b want 1 0 0000", grants, in_service, pending);
    end
    irq_src = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_mask;
    test_stall;
    test_reset_mid;
    test_level;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
